// File: rtl/ifu_pkg.sv
// Shared types and helpers for the wide instruction fetch unit.
//   ifu_state_e : fetch FSM states (RUN issues, WAIT holds one request, HALT parks)
//   redirect_e  : winning redirect cause for the current cycle
//   line_bytes  : bytes per fetch line for a given fetch width
//   lane_offset : index of the first lane a PC points into within its line
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } ifu_state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BPU  = 2'd1,
    RD_BRU  = 2'd2,
    RD_EXC  = 2'd3
  } redirect_e;

  localparam int INST_BYTES = 4;

  function automatic int line_bytes(input int fetch_width);
    return fetch_width * INST_BYTES;
  endfunction

  // Lane index selected by pc inside its line; fetch_width is a power of two.
  function automatic int lane_offset(input logic [31:0] pc_low, input int fetch_width);
    return int'((pc_low >> 2) & 32'(fetch_width - 1));
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Fetch-line FIFO.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write one entry {base, data, mask} at the tail
//   pop             : remove the head entry (ignored when empty)
//   flush           : empty the queue; takes priority over push and pop
//   head_data       : entry at the head (meaningless when empty)
//   empty, count    : occupancy status
module ifu_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign do_push   = push && (cnt != CNT_FULL);
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_wide_fetch.sv
// Wide instruction fetch unit: issues line-aligned I-cache requests, masks
// lanes ahead of a mid-line target, buffers lines, and drops stale responses
// after redirects using an epoch bit.
//   bpu_*/bru_*/exception_* : redirects, priority exception > bru > bpu
//   interrupt_stall_i       : blocks new requests (outstanding one completes)
//   icache_req_*/icache_addr_o, icache_rsp_* : line request / response
//   inst_valid_o/inst_data_o/inst_pc_o, instr_queue_ready_i : queue head
//   ifu_stall_o, ifu_flush_o, misaligned_* : status
//   fsm_state_o             : current fetch FSM state (ifu_state_e encoding)
//
// Request channel: a request transfers on every rising edge where
// icache_req_valid_o and icache_req_ready_i are both high; icache_addr_o is
// stable while valid is high and ready is low. The response returns as a
// one-cycle icache_rsp_valid_i pulse and is accepted unconditionally.
module ifu_wide_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INST_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bpu_taken_i,
  input  logic [ADDR_WIDTH-1:0]             bpu_addr_i,
  input  logic                              bru_miss_i,
  input  logic [ADDR_WIDTH-1:0]             bru_addr_i,
  input  logic                              exception_flush_i,
  input  logic [ADDR_WIDTH-1:0]             exception_addr_i,
  input  logic                              interrupt_stall_i,
  output logic                              icache_req_valid_o,
  input  logic                              icache_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             icache_addr_o,
  input  logic                              icache_rsp_valid_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] icache_rsp_data_i,
  output logic [FETCH_WIDTH-1:0]            inst_valid_o,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] inst_data_o,
  output logic [ADDR_WIDTH-1:0]             inst_pc_o,
  input  logic                              instr_queue_ready_i,
  output logic                              ifu_stall_o,
  output logic                              ifu_flush_o,
  output logic                              misaligned_exception_o,
  output logic [ADDR_WIDTH-1:0]             misaligned_addr_o,
  output logic [1:0]                        fsm_state_o
);

  localparam int LINE_B  = line_bytes(FETCH_WIDTH);
  localparam int DATA_W  = FETCH_WIDTH * INST_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_W + FETCH_WIDTH;
  localparam int CNT_W   = ((QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1) + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_B - 1));
  localparam logic [CNT_W:0]        DEPTH_C   = (CNT_W + 1)'(QUEUE_DEPTH);

  ifu_state_e              state, state_n;
  redirect_e               cause;
  logic [ADDR_WIDTH-1:0]   pc, target, line_base;
  logic                    epoch, outstanding;
  logic [ADDR_WIDTH-1:0]   req_base;
  logic [FETCH_WIDTH-1:0]  req_mask, cur_mask;
  logic                    req_epoch;
  logic                    flush_q, mis_q;
  logic [ADDR_WIDTH-1:0]   mis_addr_q;
  logic                    redirect, tgt_misaligned, clear_q;
  logic                    credit_ok, hs, rsp_accept, push, pop;
  logic [CNT_W-1:0]        q_count;
  logic [CNT_W:0]          credits_used;
  logic                    q_empty;
  logic [ENTRY_W-1:0]      head;
  logic [FETCH_WIDTH-1:0]  head_mask;
  int                      off;

  // Redirect arbitration. While halted only a trap redirect is honoured.
  always_comb begin
    cause  = RD_NONE;
    target = '0;
    if (exception_flush_i) begin
      cause  = RD_EXC;
      target = exception_addr_i;
    end else if (state != ST_HALT && bru_miss_i) begin
      cause  = RD_BRU;
      target = bru_addr_i;
    end else if (state != ST_HALT && bpu_taken_i) begin
      cause  = RD_BPU;
      target = bpu_addr_i;
    end
  end

  assign redirect       = (cause != RD_NONE);
  assign tgt_misaligned = redirect && (target[1:0] != 2'b00);
  assign clear_q        = (cause == RD_EXC) || (cause == RD_BRU);

  assign line_base     = pc & LINE_MASK;
  assign icache_addr_o = line_base;

  // A request reserves a queue slot, so count + outstanding bounds occupancy.
  assign credits_used = {1'b0, q_count} + {{CNT_W{1'b0}}, outstanding};
  assign credit_ok    = credits_used < DEPTH_C;

  // Gated by rst so the request stays low while reset is held.
  assign icache_req_valid_o = rst && (state == ST_RUN) && !redirect &&
                              !interrupt_stall_i && credit_ok;
  assign hs = icache_req_valid_o && icache_req_ready_i;

  always_comb begin
    cur_mask = '0;
    off      = lane_offset(32'(pc), FETCH_WIDTH);
    for (int k = 0; k < FETCH_WIDTH; k++) cur_mask[k] = (k >= off);
  end

  // A response is only meaningful while a request is outstanding; it is kept
  // only if no redirect arrives with it and its epoch is still current.
  assign rsp_accept = outstanding && icache_rsp_valid_i;
  assign push       = rsp_accept && (state == ST_WAIT) && !redirect &&
                      (req_epoch == epoch);
  assign pop        = instr_queue_ready_i && (|inst_valid_o);

  always_comb begin
    state_n = state;
    case (state)
      ST_RUN:  if (hs) state_n = ST_WAIT;
      ST_WAIT: if (rsp_accept) state_n = ST_RUN;
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_RUN;
    endcase
    // A redirect with a request still in flight waits in WAIT to drain it.
    if (redirect) begin
      if (tgt_misaligned)                          state_n = ST_HALT;
      else if (outstanding && !icache_rsp_valid_i) state_n = ST_WAIT;
      else                                         state_n = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      epoch       <= 1'b0;
      outstanding <= 1'b0;
      req_base    <= '0;
      req_mask    <= '0;
      req_epoch   <= 1'b0;
      flush_q     <= 1'b0;
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
    end else begin
      state <= state_n;
      if (redirect) begin
        pc    <= target;
        epoch <= ~epoch;
      end else if (hs) begin
        pc <= line_base + ADDR_WIDTH'(LINE_B);
      end
      if (hs) begin
        outstanding <= 1'b1;
        req_base    <= line_base;
        req_mask    <= cur_mask;
        req_epoch   <= epoch;
      end else if (rsp_accept) begin
        outstanding <= 1'b0;
      end
      flush_q <= clear_q || tgt_misaligned;
      if (tgt_misaligned) begin
        mis_q      <= 1'b1;
        mis_addr_q <= target;
      end else if (cause == RD_EXC) begin
        mis_q <= 1'b0;
      end
    end
  end

  ifu_fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({req_base, icache_rsp_data_i, req_mask}),
    .pop       (pop),
    .flush     (clear_q),
    .head_data (head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign head_mask    = head[FETCH_WIDTH-1:0];
  assign inst_valid_o = q_empty ? '0 : head_mask;
  assign inst_data_o  = q_empty ? '0 : head[FETCH_WIDTH +: DATA_W];
  assign inst_pc_o    = q_empty ? '0 : head[FETCH_WIDTH + DATA_W +: ADDR_WIDTH];

  assign ifu_stall_o = interrupt_stall_i || (state == ST_WAIT) || !credit_ok ||
                       (state == ST_HALT);
  assign ifu_flush_o            = flush_q;
  assign misaligned_exception_o = mis_q;
  assign misaligned_addr_o      = mis_addr_q;
  assign fsm_state_o            = state;

endmodule

// File: doc/ifu_wide_fetch.md
# ifu_wide_fetch

Parametrised next-generation instruction fetch unit that sits between the branch predictor/branch unit and the instruction queue, fronting the I-cache. It issues line-aligned fetches of `FETCH_WIDTH` instructions through a valid/ready request channel. It masks lanes that precede a mid-line redirect target and buffers fetched lines in an internal `QUEUE_DEPTH` fetch queue. It drops stale responses after redirects using an epoch bit.

## Interface
- `ADDR_WIDTH`, default 64: PC width.
- `INST_WIDTH`, default 32: instruction width. Fixed at 32; the 4-byte alignment check depends on it.
- `FETCH_WIDTH`, default 2: instructions per line. Power of 2, ≥2.
- `QUEUE_DEPTH`, default 4: fetch-queue entries. Power of 2.
- `RESET_PC`, default 0: PC after reset.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `bpu_taken_i` in 1, `bpu_addr_i` in `ADDR_WIDTH`: predicted redirect.
- `bru_miss_i` in 1, `bru_addr_i` in `ADDR_WIDTH`: mispredict redirect.
- `exception_flush_i` in 1, `exception_addr_i` in `ADDR_WIDTH`: trap redirect.
- `interrupt_stall_i` in 1: blocks new requests.
- `icache_req_valid_o` out 1, `icache_req_ready_i` in 1, `icache_addr_o` out `ADDR_WIDTH`: line request.
- `icache_rsp_valid_i` in 1, `icache_rsp_data_i` in `FETCH_WIDTH*INST_WIDTH`: line response. Lane k occupies bits [k*32 +: 32].
- `inst_valid_o` out `FETCH_WIDTH`: per-lane valid of the queue head.
- `inst_data_o` out `FETCH_WIDTH*INST_WIDTH`: data of the queue head.
- `inst_pc_o` out `ADDR_WIDTH`: line base address of the queue head.
- `instr_queue_ready_i` in 1: downstream accepts the head.
- `ifu_stall_o` out 1, `ifu_flush_o` out 1: status outputs.
- `misaligned_exception_o` out 1, `misaligned_addr_o` out `ADDR_WIDTH`: misaligned-target exception.

## Operation
- `LINE_BYTES = FETCH_WIDTH*4`. Line base = `pc & ~(LINE_BYTES-1)`. `icache_addr_o` = line base of `pc`.
- Lane mask: lane k is valid iff k ≥ `pc[log2(LINE_BYTES)-1:2]`. The mask is captured with the request.
- FSM has three states.
  - RUN: assert `icache_req_valid_o` when there is no redirect this cycle, `!interrupt_stall_i`, and credits are available (`count + outstanding < QUEUE_DEPTH`). On handshake, `pc <=` line base + `LINE_BYTES`, go to WAIT.
  - WAIT: on `icache_rsp_valid_i`, push {base, data, mask} if the tagged epoch equals the current epoch, else discard. Go to RUN. At most one request outstanding.
  - HALT: entered on a misaligned target. No requests. Left only on `exception_flush_i`.
- Redirect priority: exception > bru > bpu. The selected target loads `pc`, toggles the epoch, and sets FSM to RUN, or to WAIT if a request is still outstanding, so the stale response is drained.
  - exception and bru redirects clear the queue.
  - A bpu redirect keeps the queue.
- Target with `target[1:0] != 0`: registered `misaligned_exception_o=1`, `misaligned_addr_o=target`, enter HALT. `misaligned_exception_o` stays high until `exception_flush_i`.
- `ifu_flush_o`: registered, high for one cycle after an exception, bru, or misaligned event.
- `ifu_stall_o` (combinational) = `interrupt_stall_i` | WAIT | no credit | HALT.
- Head output: `inst_valid_o` = head mask when not empty, else 0. Pop on `instr_queue_ready_i && |inst_valid_o`.

## Timing
- Reset values:
  - All outputs are 0, except `icache_addr_o=RESET_PC`.
  - `pc=RESET_PC`, FSM=RUN, epoch=0, queue empty, `outstanding=0`.
- Request issues in the first cycle after `rst` rises. The response is pushed at the clock edge it arrives on. The head is visible the next cycle.
- Peak throughput is one line per 2 cycles with a 1-cycle cache.
- A redirect and `icache_rsp_valid_i` in the same cycle: the response is discarded.
- A flush and a pop in the same cycle: the flush wins.
- A push and a pop in the same cycle with the queue full: not possible, because credits prevent it.
- Pointers wrap modulo `QUEUE_DEPTH`.
- `interrupt_stall_i` does not cancel an outstanding request. The queue keeps draining.
- Reset asserted mid-WAIT: the state is cleared immediately. Any late response is ignored, because `outstanding=0`.

## Structure
- Package `ifu_pkg`: FSM state enum, redirect-cause enum, `LINE_BYTES` and lane-offset helper functions.
- Sub-module `ifu_fetch_queue`: synchronous FIFO with a flush input, count output, and entry = {base, data, mask}.

## Test plan
All scenarios use the default parameters and a 1-cycle-latency cache model.
- Reset release with line 0 = {0x00A00113, 0x00500093} -> request 0x0, head `inst_valid_o=2'b11`, lane0 0x00500093, lane1 0x00A00113, `inst_pc_o=0`, next request 0x8.
- `bpu_taken_i` with `bpu_addr_i=0x1004` -> next request 0x1000, head mask 2'b10, lane1 0x00000013, older queue entries preserved.
- `bru_miss_i` to 0x2000 while in WAIT -> response dropped, queue empty, `ifu_flush_o` high 1 cycle, next request 0x2000.
- `bpu_taken_i` with 0x1003 -> `misaligned_exception_o=1`, `misaligned_addr_o=0x1003`, no requests. Then `exception_flush_i` with 0x80 -> exception clears, request 0x80.
- `instr_queue_ready_i=0` for 12 cycles -> exactly 4 lines queued, `icache_req_valid_o=0`, `ifu_stall_o=1`. Release -> heads 0x0, 0x8, 0x10, 0x18 in order.
- `exception_flush_i` (0x80) and `bru_miss_i` (0x2000) in the same cycle -> request 0x80, queue cleared.
